// File: rtl/unidade_controle_if.sv
// Control-side bundle between unidade_controle (master) and the 16-bit datapath (slave).
interface unidade_controle_if #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REGS   = 8
);
  localparam int SEL_W = $clog2(NUM_REGS);

  logic                  p_Run;
  logic [DATA_WIDTH-1:0] p_DIN;
  logic                  p_GZero;
  logic                  p_IRin;
  logic [1:0]            p_BusSel;
  logic [SEL_W-1:0]      p_RegRdSel;
  logic [NUM_REGS-1:0]   p_RegWrEn;
  logic                  p_Ain;
  logic                  p_Gin;
  logic                  p_AddSub;
  logic                  p_Done;

  modport master (
    input  p_Run, p_DIN, p_GZero,
    output p_IRin, p_BusSel, p_RegRdSel, p_RegWrEn, p_Ain, p_Gin, p_AddSub, p_Done
  );

  modport slave (
    output p_Run, p_DIN, p_GZero,
    input  p_IRin, p_BusSel, p_RegRdSel, p_RegWrEn, p_Ain, p_Gin, p_AddSub, p_Done
  );
endinterface

// File: rtl/unidade_controle.sv
// Multicycle control FSM (IDLE/T1/T2/T3) for the 16-bit datapath: mv, mvi, add, sub.
// Optional macro UNIDADE_CONTROLE_MVNZ_EN turns opcode 100 into mvnz Rx,Ry (gated by p_GZero).
module unidade_controle #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REGS   = 8
) (
  input  logic                  p_Clock,
  input  logic                  p_Resetn,
  unidade_controle_if.master    bus
);
  localparam int SEL_W = $clog2(NUM_REGS);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] T1   = 2'd1;
  localparam logic [1:0] T2   = 2'd2;
  localparam logic [1:0] T3   = 2'd3;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  logic [1:0]          state;
  logic [1:0]          state_nxt;
  logic [8:0]          ir;
  logic [2:0]          ir_op;
  logic [2:0]          ir_x;
  logic [2:0]          ir_y;
  logic [NUM_REGS-1:0] x_onehot;
  logic                is_alu;

  assign ir_op    = ir[8:6];
  assign ir_x     = ir[5:3];
  assign ir_y     = ir[2:0];
  assign x_onehot = {{(NUM_REGS-1){1'b0}}, 1'b1} << ir_x;
  assign is_alu   = (ir_op == OP_ADD) || (ir_op == OP_SUB);

`ifdef UNIDADE_CONTROLE_MVNZ_EN
  logic unused_ok;
  assign unused_ok = ^bus.p_DIN[DATA_WIDTH-1:9];
`else
  logic unused_ok;
  assign unused_ok = ^{bus.p_DIN[DATA_WIDTH-1:9], bus.p_GZero};
`endif

  always_ff @(posedge p_Clock or negedge p_Resetn) begin
    if (!p_Resetn) begin
      state <= IDLE;
      ir    <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && bus.p_Run) ir <= bus.p_DIN[8:0];
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.p_Run) state_nxt = T1;
      T1:      state_nxt = is_alu ? T2 : IDLE;
      T2:      state_nxt = T3;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are a pure decode of state and IR; p_IRin is gated by reset so it is 0 while held.
  always_comb begin
    bus.p_IRin     = 1'b0;
    bus.p_BusSel   = 2'b00;
    bus.p_RegRdSel = '0;
    bus.p_RegWrEn  = '0;
    bus.p_Ain      = 1'b0;
    bus.p_Gin      = 1'b0;
    bus.p_AddSub   = 1'b0;
    bus.p_Done     = 1'b0;
    case (state)
      IDLE: bus.p_IRin = bus.p_Run & p_Resetn;
      T1: begin
        case (ir_op)
          OP_MV: begin
            bus.p_RegRdSel = SEL_W'(ir_y);
            bus.p_RegWrEn  = x_onehot;
            bus.p_Done     = 1'b1;
          end
          OP_MVI: begin
            bus.p_BusSel  = 2'b01;
            bus.p_RegWrEn = x_onehot;
            bus.p_Done    = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            bus.p_RegRdSel = SEL_W'(ir_x);
            bus.p_Ain      = 1'b1;
          end
`ifdef UNIDADE_CONTROLE_MVNZ_EN
          3'b100: begin
            if (!bus.p_GZero) begin
              bus.p_RegRdSel = SEL_W'(ir_y);
              bus.p_RegWrEn  = x_onehot;
            end
            bus.p_Done = 1'b1;
          end
`endif
          default: bus.p_Done = 1'b1;
        endcase
      end
      T2: begin
        bus.p_RegRdSel = SEL_W'(ir_y);
        bus.p_Gin      = 1'b1;
        bus.p_AddSub   = ir_op[0];
      end
      default: begin
        bus.p_BusSel  = 2'b10;
        bus.p_RegWrEn = x_onehot;
        bus.p_Done    = 1'b1;
      end
    endcase
  end
endmodule

// File: tb/tb_unidade_controle.sv
// Directed table-driven bench for unidade_controle plus a hand-written mid-instruction reset sequence.
module tb_unidade_controle;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  unidade_controle_if #(.DATA_WIDTH(16), .NUM_REGS(8)) ifc ();
  unidade_controle #(.DATA_WIDTH(16), .NUM_REGS(8)) dut (
    .p_Clock  (clk),
    .p_Resetn (rst_n),
    .bus      (ifc.master)
  );

  // {irin, bussel[1:0], rdsel[2:0], wren[7:0], ain, gin, addsub, done}
  logic [17:0] act;
  assign act = {ifc.p_IRin, ifc.p_BusSel, ifc.p_RegRdSel, ifc.p_RegWrEn,
                ifc.p_Ain, ifc.p_Gin, ifc.p_AddSub, ifc.p_Done};

  typedef struct {
    string       name;
    logic        run;
    logic [15:0] din;
    logic        gz;
    logic [17:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [17:0] ex(logic irin, logic [1:0] bs, logic [2:0] rd, logic [7:0] wr,
                                     logic ain, logic gin, logic addsub, logic done);
    return {irin, bs, rd, wr, ain, gin, addsub, done};
  endfunction

  task automatic check(string name, logic [17:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %05h expected %05h", name, act, exp);
    end
  endtask

  task automatic drive(logic run, logic [15:0] din, logic gz);
    ifc.p_Run   = run;
    ifc.p_DIN   = din;
    ifc.p_GZero = gz;
  endtask

  task automatic add(string n, logic run, logic [15:0] din, logic gz, logic [17:0] exp);
    vec_t v;
    v.name = n; v.run = run; v.din = din; v.gz = gz; v.exp = exp;
    vecs.push_back(v);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [17:0] z;
    logic [17:0] mvnz_gz0;
    z = '0;
`ifdef UNIDADE_CONTROLE_MVNZ_EN
    mvnz_gz0 = ex(0, 2'b00, 3'd1, 8'h10, 0, 0, 0, 1);
`else
    mvnz_gz0 = ex(0, 2'b00, 3'd0, 8'h00, 0, 0, 0, 1);
`endif
    add("idle",         0, 16'h0000, 0, z);
    add("mvi_fetch",    1, 16'h0058, 0, ex(1, 2'b00, 3'd0, 8'h00, 0, 0, 0, 0));
    add("mvi_t1",       0, 16'h00A5, 0, ex(0, 2'b01, 3'd0, 8'h08, 0, 0, 0, 1));
    add("mvi_idle",     0, 16'h0000, 0, z);
    add("mv_fetch",     1, 16'h000D, 0, ex(1, 2'b00, 3'd0, 8'h00, 0, 0, 0, 0));
    add("mv_t1",        0, 16'h0000, 0, ex(0, 2'b00, 3'd5, 8'h02, 0, 0, 0, 1));
    add("sub_fetch",    1, 16'h00C7, 0, ex(1, 2'b00, 3'd0, 8'h00, 0, 0, 0, 0));
    add("sub_t1",       0, 16'h0000, 0, ex(0, 2'b00, 3'd0, 8'h00, 1, 0, 0, 0));
    add("sub_t2_run",   1, 16'h0058, 0, ex(0, 2'b00, 3'd7, 8'h00, 0, 1, 1, 0));
    add("sub_t3",       0, 16'h0000, 0, ex(0, 2'b10, 3'd0, 8'h01, 0, 0, 0, 1));
    add("sub_idle",     0, 16'h0000, 0, z);
    add("b2b_mvi_fet",  1, 16'h0050, 0, ex(1, 2'b00, 3'd0, 8'h00, 0, 0, 0, 0));
    add("b2b_mvi_t1",   1, 16'h1234, 0, ex(0, 2'b01, 3'd0, 8'h04, 0, 0, 0, 1));
    add("b2b_add_fet",  1, 16'h00B6, 0, ex(1, 2'b00, 3'd0, 8'h00, 0, 0, 0, 0));
    add("b2b_add_t1",   1, 16'h0000, 0, ex(0, 2'b00, 3'd6, 8'h00, 1, 0, 0, 0));
    add("b2b_add_t2",   0, 16'h0000, 0, ex(0, 2'b00, 3'd6, 8'h00, 0, 1, 0, 0));
    add("b2b_add_t3",   1, 16'h0000, 0, ex(0, 2'b10, 3'd0, 8'h40, 0, 0, 0, 1));
    add("op100_fet",    1, 16'h0121, 0, ex(1, 2'b00, 3'd0, 8'h00, 0, 0, 0, 0));
    add("op100_gz0",    0, 16'h0000, 0, mvnz_gz0);
    add("op100_fet2",   1, 16'h0121, 1, ex(1, 2'b00, 3'd0, 8'h00, 0, 0, 0, 0));
    add("op100_gz1",    0, 16'h0000, 1, ex(0, 2'b00, 3'd0, 8'h00, 0, 0, 0, 1));
    add("nop111_fet",   1, 16'h01EA, 0, ex(1, 2'b00, 3'd0, 8'h00, 0, 0, 0, 0));
    add("nop111_t1",    0, 16'h0000, 0, ex(0, 2'b00, 3'd0, 8'h00, 0, 0, 0, 1));
    add("hi_bits_fet",  1, 16'hFE38, 0, ex(1, 2'b00, 3'd0, 8'h00, 0, 0, 0, 0));
    add("hi_bits_mv",   0, 16'h0000, 0, ex(0, 2'b00, 3'd0, 8'h80, 0, 0, 0, 1));
    add("end_idle",     0, 16'h0000, 0, z);

    drive(1, 16'h0058, 0);
    repeat (2) @(posedge clk);
    #1 check("reset_hold", z);
    drive(0, 16'h0000, 0);
    @(negedge clk) rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(posedge clk);
      #1 drive(vecs[i].run, vecs[i].din, vecs[i].gz);
      @(negedge clk) check(vecs[i].name, vecs[i].exp);
    end

    // add R2,R3 interrupted by reset in T2: no T3 write may follow
    @(posedge clk); #1 drive(1, 16'h0093, 0);
    @(negedge clk) check("rst_add_fetch", ex(1, 2'b00, 3'd0, 8'h00, 0, 0, 0, 0));
    @(posedge clk); #1 drive(0, 16'h0000, 0);
    @(negedge clk) check("rst_add_t1", ex(0, 2'b00, 3'd2, 8'h00, 1, 0, 0, 0));
    @(posedge clk); #1 drive(1, 16'h0000, 0);
    @(negedge clk) check("rst_add_t2", ex(0, 2'b00, 3'd3, 8'h00, 0, 1, 0, 0));
    #2 rst_n = 1'b0;
    #1 check("rst_async", z);
    @(posedge clk); #1 check("rst_next", z);
    drive(0, 16'h0000, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1 check("rst_rel_1", z);
    @(posedge clk); #1 check("rst_rel_2", z);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/unidade_controle.md
Name: unidade_controle

Overview:
- Multicycle control FSM for the 16-bit datapath.
- Captures an instruction word from p_DIN and sequences the datapath one step per clock.
- Drives the 2-bit select of the 4:1 bus multiplexer (00 = register read data, 01 = p_DIN, 10 = ALU result register G, 11 = unused).
- Also drives register-file read select, one-hot register write enables, the A/G load enables and the ALU add/sub control. Sits directly upstream of the bus multiplexer.

Parameters:
DATA_WIDTH, 16, width of p_DIN (only bits [8:0] are decoded)
NUM_REGS, 8, number of general registers (width of p_RegWrEn; read select is log2(NUM_REGS) bits)

Ports:
p_Clock  input  1  clock; all state changes on rising edge
p_Resetn  input  1  asynchronous reset, active-low
p_Run  input  1  start request, sampled only in IDLE
p_DIN  input  DATA_WIDTH  instruction word (in IDLE) / immediate (in T1 of mvi)
p_GZero  input  1  G register equals zero (used only with optional feature)
p_IRin  output  1  high in the cycle the instruction is captured
p_BusSel  output  2  bus multiplexer select
p_RegRdSel  output  3  register-file read address
p_RegWrEn  output  NUM_REGS  one-hot register write enable
p_Ain  output  1  load A register from bus
p_Gin  output  1  load G register from ALU
p_AddSub  output  1  0 = add, 1 = sub
p_Done  output  1  one-cycle pulse in final step of instruction

Behaviour:
- Instruction format, IR[8:0] = {III, XXX, YYY}:
  - 000 mv Rx,Ry
  - 001 mvi Rx,#D
  - 010 add Rx,Ry
  - 011 sub Rx,Ry
  - 100–111 NOP (unless the optional feature is enabled)
- Internal 9-bit IR is loaded with p_DIN[8:0] on the edge where state=IDLE and p_Run=1. p_DIN[15:9] is ignored.
- States: IDLE, T1, T2, T3.
  - IDLE -> T1 when p_Run=1; otherwise stay.
  - T1 -> IDLE for mv/mvi/NOP; T1 -> T2 for add/sub.
  - T2 -> T3.
  - T3 -> IDLE.
- Outputs are combinational from state and IR. Default for every output is 0 and p_BusSel=00.
  - IDLE: p_IRin = p_Run.
  - mv, T1: p_BusSel=00, p_RegRdSel=Y, p_RegWrEn[X]=1, p_Done=1.
  - mvi, T1: p_BusSel=01, p_RegWrEn[X]=1, p_Done=1. p_DIN must hold the immediate during T1.
  - add/sub, T1: p_BusSel=00, p_RegRdSel=X, p_Ain=1.
  - add/sub, T2: p_BusSel=00, p_RegRdSel=Y, p_Gin=1, p_AddSub=0 (add) / 1 (sub).
  - add/sub, T3: p_BusSel=10, p_RegWrEn[X]=1, p_Done=1.
  - NOP, T1: p_Done=1 only; no enables asserted.
- Latency from p_Run sampled:
  - mv/mvi/NOP: p_Done in next cycle (2 cycles total including fetch).
  - add/sub: p_Done in 3rd cycle after fetch.
- p_Run while not in IDLE is ignored.
- p_Run held high: a new fetch occurs in the IDLE cycle immediately after p_Done, with no extra idle cycle. p_IRin and p_Done are never high in the same cycle.
- Exactly one bit of p_RegWrEn is high when writing, never more.
- X=Y is legal (e.g. add R2,R2 doubles R2).
- Reset (asynchronous, any state including mid-instruction): state=IDLE, IR=0, and all outputs 0 except p_IRin (0 while reset asserted). The aborted instruction performs no further writes.

Optional Feature:
- Macro: UNIDADE_CONTROLE_MVNZ_EN.
- Defined: opcode 100 = mvnz Rx,Ry, a single-step instruction in T1:
  - p_GZero=0: p_BusSel=00, p_RegRdSel=Y, p_RegWrEn[X]=1, p_Done=1.
  - p_GZero=1: p_Done=1 only.
- Not defined: 100 is NOP and p_GZero is unused.

Test Plan:
- Reset low mid-add at T2 -> next cycle state IDLE, p_RegWrEn=0, p_Done=0, p_Gin=0; release and idle -> all outputs 0.
- p_DIN=9'b001_011_000, p_Run=1; T1 with p_DIN=16'h00A5 -> p_BusSel=01, p_RegWrEn=8'b0000_1000, p_Done=1, then IDLE.
- mv R1,R5 (p_DIN=9'b000_001_101) -> T1: p_RegRdSel=5, p_BusSel=00, p_RegWrEn=8'b0000_0010, p_Done=1.
- sub R0,R7 -> T1 p_RegRdSel=0, p_Ain=1; T2 p_RegRdSel=7, p_Gin=1, p_AddSub=1; T3 p_BusSel=10, p_RegWrEn=8'b0000_0001, p_Done=1.
- p_Run held high with mvi then add back-to-back -> p_IRin high in the IDLE cycle directly after each p_Done; p_Run toggled during T2 has no effect.
- Opcode 100 with p_GZero=0: macro undefined -> p_Done only, p_RegWrEn=0; macro defined -> p_RegWrEn[X]=1; macro defined with p_GZero=1 -> p_Done only.
